multdiv: RTL and testbench

Iterative 32-bit signed multiply/divide unit in the execute stage, beside the ALU. Started by a one-cycle command pulse, runs a fixed 32-iteration shift-add or restoring-divide sequence, then presents a 32-bit result and exception flag. Its result feeds the execute-stage 32-bit result select ahead of writeback. The pipeline stalls while `busy` is high.

---
 rtl/multdiv_pkg.sv | 23 ++
 rtl/multdiv_if.sv | 29 ++
 rtl/multdiv_ctrl.sv | 86 ++++++++
 rtl/multdiv.sv | 131 +++++++++++++
 tb/tb_multdiv.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   WIDTH_DEF : default operand/result width (iteration count equals width)
//   INT_MIN   : most negative two's complement value at the default width
//   state_t   : controller state encoding
//   op_t      : operation latched at start
package multdiv_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [WIDTH_DEF-1:0] INT_MIN = {1'b1, {(WIDTH_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

endpackage

// File: rtl/multdiv_if.sv
// Command/result bundle between the execute stage and the multiply/divide unit.
//   data_operandA/B : operands, sampled only on a start edge
//   ctrl_MULT/DIV   : one-cycle start pulses
//   data_result     : product low half or quotient (registered)
//   data_exception  : overflow / divide-by-zero (registered)
//   data_resultRDY  : one-cycle result-valid pulse
//   busy            : unit occupied, pipeline must stall
interface multdiv_if #(
    parameter int WIDTH = multdiv_pkg::WIDTH_DEF
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_ctrl.sv
// Sequencer for the multiply/divide unit: state machine, iteration counter
// and start priority / abort handling.
//   clock, reset          : clock and synchronous active-high reset
//   start_mult, start_div : start pulses (multiply wins when both are high)
//   load                  : latch operands and clear the datapath this edge
//   step                  : perform one iteration this edge
//   done                  : commit the signed result this edge
//   op_sel                : operation to latch together with load
//   busy                  : an operation is in flight
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no operation in flight, waiting for a start
// ST_RUN  | one iteration per cycle, counter 0..WIDTH-1
// ST_DONE | final cycle; result and RDY are registered at its closing edge
//           unless a new start aborts it
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic start_mult,
    input  logic start_div,
    output logic load,
    output logic step,
    output logic done,
    output op_t  op_sel,
    output logic busy
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          start;

    assign start  = start_mult | start_div;
    assign op_sel = start_mult ? OP_MULT : OP_DIV;
    assign busy   = (state_q != ST_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        done    = 1'b0;
        // A start in any state (re)launches; in RUN/DONE this silently
        // drops the operation in flight.
        if (start) begin
            load    = 1'b1;
            state_d = ST_RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_RUN: begin
                    step  = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end
                end
                ST_DONE: begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/multdiv.sv
// Iterative signed multiply/divide unit for the execute stage.
// Works on operand magnitudes: shift-add multiply, restoring divide, one
// bit per cycle, sign applied when the result is committed. Fixed latency
// of WIDTH+1 cycles from the start edge to the RDY pulse.
//   clock, reset : clock and synchronous active-high reset
//   bus          : command/result bundle (slave side)
module multdiv
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic     clock,
    input  logic     reset,
    multdiv_if.slave bus
);

    localparam logic [WIDTH-1:0] INT_MIN_W = INT_MIN[WIDTH_DEF-1 -: WIDTH];

    logic load, step, done, busy;
    op_t  op_sel, op_q;

    logic               sign_q;
    logic               bzero_q;
    logic [2*WIDTH-1:0] work_a;   // multiply: shifted |A|; divide: |A| in low half
    logic [WIDTH-1:0]   work_b;   // multiply: shifted |B|; divide: |B|
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic               q_bit;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo_s;
    logic               mult_ovf;
    logic [WIDTH-1:0]   result_d, result_q;
    logic               exc_d, exc_q, rdy_q;

    multdiv_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clock      (clock),
        .reset      (reset),
        .start_mult (bus.ctrl_MULT),
        .start_div  (bus.ctrl_DIV),
        .load       (load),
        .step       (step),
        .done       (done),
        .op_sel     (op_sel),
        .busy       (busy)
    );

    // |INT_MIN| wraps to INT_MIN, which is the correct unsigned magnitude.
    assign mag_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign mag_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

    // Restoring step: the borrow out of the trial subtraction decides the
    // quotient bit. |B| <= 2^(WIDTH-1), so the borrow bit is exact.
    assign rem_sh   = {rem_q, work_a[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, work_b};
    assign q_bit    = ~rem_diff[WIDTH];

    assign prod  = sign_q ? -acc : acc;
    assign quo_s = sign_q ? -quo_q : quo_q;

    // Product fits in WIDTH bits only if the top WIDTH+1 bits agree.
    assign mult_ovf = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));

    always_comb begin
        result_d = '0;
        exc_d    = 1'b0;
        if (op_q == OP_MULT) begin
            result_d = prod[WIDTH-1:0];
            exc_d    = mult_ovf;
        end else if (bzero_q) begin
            result_d = '0;
            exc_d    = 1'b1;
        end else begin
            // Only INT_MIN / -1 yields a positive quotient of magnitude 2^(WIDTH-1).
            result_d = quo_s;
            exc_d    = !sign_q && (quo_q == INT_MIN_W);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q     <= OP_MULT;
            sign_q   <= 1'b0;
            bzero_q  <= 1'b0;
            work_a   <= '0;
            work_b   <= '0;
            acc      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            rdy_q <= done;
            if (load) begin
                op_q    <= op_sel;
                sign_q  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                bzero_q <= (bus.data_operandB == '0);
                work_a  <= {{WIDTH{1'b0}}, mag_a};
                work_b  <= mag_b;
                acc     <= '0;
                rem_q   <= '0;
                quo_q   <= '0;
            end else if (step) begin
                work_a <= work_a << 1;
                if (op_q == OP_MULT) begin
                    if (work_b[0]) begin
                        acc <= acc + work_a;
                    end
                    work_b <= work_b >> 1;
                end else begin
                    rem_q <= q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], q_bit};
                end
            end
            if (done) begin
                result_q <= result_d;
                exc_q    <= exc_d;
            end
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy;

endmodule

// File: tb/tb_multdiv.sv
// Self-checking bench for multdiv: directed cases plus randomized operations
// checked against a plain-arithmetic reference model.
module tb_multdiv;

    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    multdiv_if #(.WIDTH(32)) bus ();

    multdiv #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Reference: signed arithmetic on wide integers.
    function automatic void ref_model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic e);
        longint p;
        int     q;
        if (!is_div) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p != longint'($signed(p[31:0])));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            r = 32'h80000000;
            e = 1'b1;
        end else begin
            q = $signed(a) / $signed(b);
            r = q;
            e = 1'b0;
        end
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] r;
        logic [31:0] special [4];
        special = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000};
        r = $urandom;
        case ($urandom_range(0, 3))
            0: return r;
            1: return 32'(int'($urandom_range(0, 200)) - 100);
            2: return {{16{r[15]}}, r[15:0]};
            default: return special[$urandom_range(0, 3)];
        endcase
    endfunction

    // Present a start at the next rising edge (E0); return 1 ns after E0
    // with the start removed and the operand inputs scrambled.
    task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        @(posedge clock);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    // Cycles from the start edge to the RDY pulse (bounded), plus how many of
    // those cycles showed busy.
    task automatic wait_rdy(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        while (bus.data_resultRDY !== 1'b1 && lat < 100) begin
            if (bus.busy === 1'b1) busy_n++;
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset             = 1'b1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (bus.data_result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 00000000", bus.data_result); end
        checks++; if (bus.data_exception !== 1'b0) begin errors++; $display("FAIL reset_exc: got %b want 0", bus.data_exception); end
        checks++; if (bus.data_resultRDY !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", bus.data_resultRDY); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] ta [6];
        logic [31:0] tbv [6];
        bit          tdiv [6];
        logic [31:0] tres [6];
        logic        texc [6];
        int          lat, bn;
        ta   = '{32'd7, 32'h00010000, 32'h80000000, 32'hFFFFFFF9, 32'd100, 32'h80000000};
        tbv  = '{32'hFFFFFFFA, 32'h00010000, 32'd1, 32'd2, 32'd0, 32'hFFFFFFFF};
        tdiv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tres = '{32'hFFFFFFD6, 32'h00000000, 32'h80000000, 32'hFFFFFFFD, 32'h00000000, 32'h80000000};
        texc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            start_op(!tdiv[i], tdiv[i], ta[i], tbv[i]);
            wait_rdy(lat, bn);
            checks++; if (lat != 33) begin errors++; $display("FAIL dir%0d_latency: got %0d want 33", i, lat); end
            checks++; if (bn != 33) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d want 33", i, bn); end
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_at_rdy: got %b want 0", i, bus.busy); end
            checks++; if (bus.data_result !== tres[i]) begin errors++; $display("FAIL dir%0d_result: got %h want %h", i, bus.data_result, tres[i]); end
            checks++; if (bus.data_exception !== texc[i]) begin errors++; $display("FAIL dir%0d_exc: got %b want %b", i, bus.data_exception, texc[i]); end
            @(posedge clock);
            #1;
            checks++; if (bus.data_resultRDY !== 1'b0) begin errors++; $display("FAIL dir%0d_rdy_width: got %b want 0", i, bus.data_resultRDY); end
            checks++; if (bus.data_result !== tres[i]) begin errors++; $display("FAIL dir%0d_hold: got %h want %h", i, bus.data_result, tres[i]); end
        end
    endtask

    task automatic test_abort();
        int lat, bn;
        start_op(1'b1, 1'b0, 32'd3, 32'd3);
        repeat (9) @(posedge clock);
        start_op(1'b0, 1'b1, 32'd9, 32'd3);
        wait_rdy(lat, bn);
        checks++; if (10 + lat != 43) begin errors++; $display("FAIL abort_rdy_cycle: got E0+%0d want E0+43", 10 + lat); end
        checks++; if (bus.data_result !== 32'd3) begin errors++; $display("FAIL abort_result: got %h want 00000003", bus.data_result); end
        checks++; if (bus.data_exception !== 1'b0) begin errors++; $display("FAIL abort_exc: got %b want 0", bus.data_exception); end
    endtask

    task automatic test_both_start();
        int lat, bn;
        start_op(1'b1, 1'b1, 32'd6, 32'd3);
        wait_rdy(lat, bn);
        checks++; if (lat != 33) begin errors++; $display("FAIL both_latency: got %0d want 33", lat); end
        checks++; if (bus.data_result !== 32'd18) begin errors++; $display("FAIL both_result: got %h want 00000012", bus.data_result); end
    endtask

    task automatic test_reset_mid_op();
        int lat, bn;
        start_op(1'b1, 1'b0, 32'h00001234, 32'h00000055);
        repeat (19) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (bus.data_result !== 32'd0) begin errors++; $display("FAIL midrst_result: got %h want 00000000", bus.data_result); end
        checks++; if (bus.data_exception !== 1'b0) begin errors++; $display("FAIL midrst_exc: got %b want 0", bus.data_exception); end
        checks++; if (bus.data_resultRDY !== 1'b0) begin errors++; $display("FAIL midrst_rdy: got %b want 0", bus.data_resultRDY); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        reset = 1'b0;
        start_op(1'b1, 1'b0, 32'd2, 32'd2);
        wait_rdy(lat, bn);
        checks++; if (lat != 33) begin errors++; $display("FAIL midrst_restart_latency: got %0d want 33", lat); end
        checks++; if (bus.data_result !== 32'd4) begin errors++; $display("FAIL midrst_restart_result: got %h want 00000004", bus.data_result); end
    endtask

    task automatic test_back_to_back();
        int          lat, bn;
        logic [31:0] r1, r2;
        logic        e1, e2;
        ref_model(1'b1, 32'hFFFF0000, 32'd7, r1, e1);
        ref_model(1'b0, 32'h00012345, 32'hFFFFFF00, r2, e2);
        start_op(1'b0, 1'b1, 32'hFFFF0000, 32'd7);
        wait_rdy(lat, bn);
        checks++; if (bus.data_result !== r1) begin errors++; $display("FAIL b2b_first_result: got %h want %h", bus.data_result, r1); end
        // Start sampled on the edge that ends the RDY cycle (E0+34).
        start_op(1'b1, 1'b0, 32'h00012345, 32'hFFFFFF00);
        checks++; if (bus.data_result !== r1) begin errors++; $display("FAIL b2b_hold_after_start: got %h want %h", bus.data_result, r1); end
        wait_rdy(lat, bn);
        checks++; if (34 + lat != 67) begin errors++; $display("FAIL b2b_rdy_cycle: got E0+%0d want E0+67", 34 + lat); end
        checks++; if (bus.data_result !== r2) begin errors++; $display("FAIL b2b_second_result: got %h want %h", bus.data_result, r2); end
        checks++; if (bus.data_exception !== e2) begin errors++; $display("FAIL b2b_second_exc: got %b want %b", bus.data_exception, e2); end
    endtask

    task automatic test_random();
        int          lat, bn;
        bit          is_div;
        logic [31:0] a, b, r;
        logic        e;
        for (int n = 0; n < 40; n++) begin
            is_div = 1'($urandom_range(0, 1));
            a      = rand_operand();
            b      = rand_operand();
            ref_model(is_div, a, b, r, e);
            start_op(!is_div, is_div, a, b);
            wait_rdy(lat, bn);
            checks++; if (lat != 33) begin errors++; $display("FAIL rnd%0d_latency: got %0d want 33", n, lat); end
            checks++; if (bus.data_result !== r) begin errors++; $display("FAIL rnd%0d_result: op=%s a=%h b=%h got %h want %h", n, is_div ? "div" : "mul", a, b, bus.data_result, r); end
            checks++; if (bus.data_exception !== e) begin errors++; $display("FAIL rnd%0d_exc: op=%s a=%h b=%h got %b want %b", n, is_div ? "div" : "mul", a, b, bus.data_exception, e); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_both_start();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
